aurora_lane_striper: RTL and testbench
======================================

AURORA_LANE_STRIPER -- requirements
Module: aurora_lane_striper

Interface
REQ-001 Parameter LANES, 4, number of serial lanes, legal range 1..8.
REQ-002 Parameter CC_PERIOD, 5000, clock cycles between clock-compensation bursts, minimum 16.
REQ-003 Parameter CC_LEN, 6, cycles per clock-compensation burst, range 1..15.
REQ-004 Port clk  input  1  single clock, rising-edge.
REQ-005 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port channel_up  input  1  channel initialisation complete; framing is allowed only while high.
REQ-007 Port s_axi_tvalid  input  1  AXI-stream beat valid.
REQ-008 Port s_axi_tready  output  1  AXI-stream beat accepted when high together with tvalid.
REQ-009 Port s_axi_tdata  input  LANES*16  beat payload; bits [16i+15:16i] belong to lane i.
REQ-010 Port s_axi_tkeep  input  LANES  per-lane word valid; contiguous from lane 0; all ones except on the last beat.
REQ-011 Port s_axi_tlast  input  1  final beat of the frame.
REQ-012 Port lane_data  output  LANES x 16  per-lane byte pair presented to the 8b/10b encoders.
REQ-013 Port lane_k  output  LANES x 2  per-byte control-character flag.
REQ-014 Port frame_abort  output  1  one-cycle pulse when a frame is cut off by channel_up falling.

Function
REQ-015 Character codes, with k=1 on both bytes: IDLE = BC,BC; SCP = 5C,FB; ECP = FD,FE; PAD = 9C,9C; CC = F7,F7.
REQ-016 lane_data, lane_k and frame_abort are registered; each output cycle reflects the state and the accepted beat of the previous cycle.
REQ-017 The FSM has four states: IDLE, SOF, DATA, EOF.
REQ-018 IDLE: all lanes send IDLE; the FSM moves to SOF when channel_up and s_axi_tvalid are both high.
REQ-019 SOF: lane 0 sends SCP and the other lanes send IDLE; s_axi_tready=0; the FSM moves to DATA.
REQ-020 DATA: s_axi_tready=1.
- On handshake, lane i sends tdata word i with k=00 when tkeep[i]=1, and PAD when tkeep[i]=0.
- With no handshake, all lanes send IDLE.
- A handshake with tlast moves the FSM to EOF.
REQ-021 EOF: lane 0 sends ECP and the other lanes send IDLE; tready=0; the FSM returns to IDLE, so a back-to-back frame gets its own SOF.
REQ-022 s_axi_tready is combinational from state, CC activity and channel_up; it is never high outside DATA.
REQ-023 A free-running cc_cnt counts 0..CC_PERIOD-1 and wraps.
- At the wrap, a CC burst of CC_LEN cycles begins on the next cycle.
- During the burst, all lanes send CC, tready=0 and the FSM state is frozen.
- After the burst, the pending SOF/DATA/EOF output resumes unchanged.
REQ-024 A CC burst preempts SOF and EOF; the frozen character is sent after the burst.
REQ-025 channel_up low in any state: tready=0 the same cycle, and the FSM goes to IDLE on the next edge.
- When the state left was SOF or DATA, frame_abort pulses for one cycle.
- No ECP is sent.
- CC bursts continue regardless of channel_up.
REQ-026 A tkeep of all zeros on a tlast beat is legal: all lanes send PAD, then EOF follows.

Reset
REQ-027 Asserting rst_n low immediately forces:
- state IDLE, cc_cnt 0, CC burst inactive;
- lane_data to BC,BC on every lane, lane_k 11 on every lane;
- frame_abort 0, s_axi_tready 0.
REQ-028 Reset asserted mid-frame drops the frame silently, with no frame_abort pulse; after release, operation starts in IDLE with a full CC_PERIOD.

Structure
REQ-029 The character constants, the state enum typedef and the lane word width (16) belong in aurora_pkg.
REQ-030 A sub-module aurora_cc_timer (counter plus burst flag, parameters CC_PERIOD and CC_LEN) is instantiated once; striping and the FSM stay in the top level.

Verification
REQ-031 LANES=4: channel_up=1 and one beat (tdata=0x0004_0003_0002_0001, tkeep=1111, tlast=1) -> outputs over consecutive cycles SCP/IDLE x3, then words 0001..0004 k=00, then ECP/IDLE x3, then all IDLE.
REQ-032 Last beat with tkeep=0011 -> lanes 0-1 carry data, lanes 2-3 carry 9C,9C k=11.
REQ-033 CC_PERIOD=16, CC_LEN=6, and a 10-beat frame streamed continuously -> exactly 6 CC cycles at each wrap with tready=0; all 10 beats are delivered in order with none lost or duplicated.
REQ-034 channel_up dropped on the 3rd DATA beat -> tready falls the same cycle, one frame_abort pulse, no ECP, all-IDLE output after that.
REQ-035 rst_n pulsed low asynchronously mid-DATA -> outputs go to IDLE and tready to 0 before the next clock edge; a fresh frame after release starts with SCP.
REQ-036 Two back-to-back single-beat frames -> sequence SCP, data, ECP, SCP, data, ECP with no IDLE-only cycle between ECP and the second SCP being required.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora lane striper: character codes, lane word width
// and the framing FSM state type.
package aurora_pkg;

  localparam int unsigned LaneW = 16;

  // First transmitted byte sits in [15:8].
  localparam logic [LaneW-1:0] CharIdle = 16'hBCBC;
  localparam logic [LaneW-1:0] CharScp  = 16'h5CFB;
  localparam logic [LaneW-1:0] CharEcp  = 16'hFDFE;
  localparam logic [LaneW-1:0] CharPad  = 16'h9C9C;
  localparam logic [LaneW-1:0] CharCc   = 16'hF7F7;

  localparam logic [1:0] KCtrl = 2'b11;
  localparam logic [1:0] KData = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StSof,
    StData,
    StEof
  } state_e;

endpackage

// File: rtl/aurora_lane_striper_if.sv
// AXI-stream user interface feeding the lane striper.
interface aurora_lane_striper_if #(
  parameter int unsigned LANES = 4
);
  import aurora_pkg::*;

  logic                     tvalid;
  logic                     tready;
  logic [LANES*LaneW-1:0]   tdata;
  logic [LANES-1:0]         tkeep;
  logic                     tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/aurora_cc_timer.sv
// Free-running clock-compensation timer: raises cc_active_o for CC_LEN cycles
// starting the cycle after each CC_PERIOD wrap.
module aurora_cc_timer #(
  parameter int unsigned CC_PERIOD = 5000,
  parameter int unsigned CC_LEN    = 6
) (
  input  logic clk,
  input  logic rst_n,
  output logic cc_active_o
);

  localparam int unsigned CntW = $clog2(CC_PERIOD);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic [3:0]      burst_d, burst_q;

  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    burst_d = burst_q;
    if (burst_q != 4'd0) begin
      burst_d = burst_q - 4'd1;
    end
    if (cnt_q == CntW'(CC_PERIOD - 1)) begin
      cnt_d   = '0;
      burst_d = 4'(CC_LEN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      burst_q <= 4'd0;
    end else begin
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
    end
  end

  assign cc_active_o = (burst_q != 4'd0);

endmodule

// File: rtl/aurora_lane_striper.sv
// Aurora lane striper: frames AXI-stream beats onto LANES lanes with SCP/ECP delimiters,
// PAD fill for unused lanes and periodic clock-compensation bursts.
module aurora_lane_striper
  import aurora_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned CC_PERIOD = 5000,
  parameter int unsigned CC_LEN    = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        channel_up,
  aurora_lane_striper_if.slave        s_axi,
  output logic [LANES-1:0][LaneW-1:0] lane_data,
  output logic [LANES-1:0][1:0]       lane_k,
  output logic                        frame_abort
);

  state_e state_d, state_q;
  logic   cc_active;
  logic   hs;

  logic [LANES-1:0][LaneW-1:0] lane_data_d, lane_data_q;
  logic [LANES-1:0][1:0]       lane_k_d, lane_k_q;
  logic                        frame_abort_d, frame_abort_q;

  aurora_cc_timer #(
    .CC_PERIOD(CC_PERIOD),
    .CC_LEN   (CC_LEN)
  ) u_cc_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .cc_active_o(cc_active)
  );

  assign s_axi.tready = (state_q == StData) && !cc_active && channel_up;
  assign hs           = s_axi.tvalid && s_axi.tready;

  // Link loss wins over the CC freeze so a dropped channel always returns to idle.
  always_comb begin
    state_d       = state_q;
    frame_abort_d = 1'b0;
    if (!channel_up) begin
      state_d       = StIdle;
      frame_abort_d = (state_q == StSof) || (state_q == StData);
    end else if (!cc_active) begin
      unique case (state_q)
        StIdle:  if (s_axi.tvalid) state_d = StSof;
        StSof:   state_d = StData;
        StData:  if (hs && s_axi.tlast) state_d = StEof;
        StEof:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_data_d[i] = cc_active ? CharCc : CharIdle;
      lane_k_d[i]    = KCtrl;
    end
    if (!cc_active && channel_up) begin
      unique case (state_q)
        StSof: lane_data_d[0] = CharScp;
        StEof: lane_data_d[0] = CharEcp;
        StData: begin
          if (hs) begin
            for (int i = 0; i < LANES; i++) begin
              if (s_axi.tkeep[i]) begin
                lane_data_d[i] = s_axi.tdata[LaneW*i +: LaneW];
                lane_k_d[i]    = KData;
              end else begin
                lane_data_d[i] = CharPad;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      lane_data_q   <= {LANES{CharIdle}};
      lane_k_q      <= {LANES{KCtrl}};
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_data_q   <= lane_data_d;
      lane_k_q      <= lane_k_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign lane_data   = lane_data_q;
  assign lane_k      = lane_k_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_aurora_lane_striper.sv
// Scoreboard bench for aurora_lane_striper: stimulus pushes expected lane symbols,
// a negedge monitor pops and compares, and CC slots are predicted from cycle count.
`timescale 1ns/1ps
module tb_aurora_lane_striper;

  localparam int unsigned LANES     = 4;
  localparam int unsigned CC_PERIOD = 16;
  localparam int unsigned CC_LEN    = 6;

  localparam logic [15:0] IDLE_C = 16'hBCBC;
  localparam logic [15:0] SCP_C  = 16'h5CFB;
  localparam logic [15:0] ECP_C  = 16'hFDFE;
  localparam logic [15:0] PAD_C  = 16'h9C9C;
  localparam logic [15:0] CC_C   = 16'hF7F7;

  typedef logic [LANES-1:0][15:0] word_t;
  typedef logic [LANES-1:0][1:0]  kvec_t;
  typedef struct packed {
    word_t d;
    kvec_t k;
  } sym_t;

  logic  clk        = 1'b0;
  logic  rst_n      = 1'b1;
  logic  channel_up = 1'b0;
  word_t lane_data;
  kvec_t lane_k;
  logic  frame_abort;

  aurora_lane_striper_if #(.LANES(LANES)) s_axi ();

  aurora_lane_striper #(
    .LANES    (LANES),
    .CC_PERIOD(CC_PERIOD),
    .CC_LEN   (CC_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .channel_up (channel_up),
    .s_axi      (s_axi),
    .lane_data  (lane_data),
    .lane_k     (lane_k),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int   checks     = 0;
  int   passes     = 0;
  int   edge_cnt   = 0;
  int   abort_seen = 0;
  int   abort_exp  = 0;
  sym_t exp_q[$];

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic sym_t all_of(input logic [15:0] c);
    sym_t s;
    for (int i = 0; i < LANES; i++) begin
      s.d[i] = c;
      s.k[i] = 2'b11;
    end
    return s;
  endfunction

  function automatic sym_t ctrl0(input logic [15:0] c);
    sym_t s;
    s = all_of(IDLE_C);
    s.d[0] = c;
    return s;
  endfunction

  // Reference: kept lanes carry their data word as data, the rest carry PAD.
  function automatic sym_t beat_sym(input logic [LANES*16-1:0] data, input logic [LANES-1:0] keep);
    sym_t s;
    for (int i = 0; i < LANES; i++) begin
      if (keep[i]) begin
        s.d[i] = data[16*i +: 16];
        s.k[i] = 2'b00;
      end else begin
        s.d[i] = PAD_C;
        s.k[i] = 2'b11;
      end
    end
    return s;
  endfunction

  function automatic logic [LANES*16-1:0] rand_data();
    return {$urandom(), $urandom()};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) edge_cnt = 0;
    else edge_cnt = edge_cnt + 1;
  end

  // Bursts occupy output samples PERIOD+1 .. PERIOD+LEN after reset release, then repeat.
  always @(negedge clk) begin
    sym_t cur;
    sym_t e;
    logic is_idle, is_cc, exp_cc, cc_now;
    if (rst_n) begin
      cur.d   = lane_data;
      cur.k   = lane_k;
      is_idle = (cur == all_of(IDLE_C));
      is_cc   = (cur == all_of(CC_C));
      exp_cc  = (edge_cnt > CC_PERIOD) && (((edge_cnt - CC_PERIOD - 1) % CC_PERIOD) < CC_LEN);
      cc_now  = (edge_cnt >= CC_PERIOD) && (((edge_cnt - CC_PERIOD) % CC_PERIOD) < CC_LEN);
      check("cc_slot", is_cc == exp_cc,
            $sformatf("cycle %0d: cc output %0b, required %0b", edge_cnt, is_cc, exp_cc));
      if (cc_now)
        check("tready_in_cc", s_axi.tready == 1'b0,
              $sformatf("cycle %0d: tready %0b, required 0", edge_cnt, s_axi.tready));
      if (frame_abort) abort_seen++;
      if (!is_idle && !is_cc) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b0,
                $sformatf("got %h k %h, required idle", cur.d, cur.k));
        end else begin
          e = exp_q.pop_front();
          check("lane_output", cur == e,
                $sformatf("got %h k %h, required %h k %h", cur.d, cur.k, e.d, e.k));
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge; returns once the beat is taken or the budget runs out.
  task automatic offer_beat(input logic [LANES*16-1:0] data, input logic [LANES-1:0] keep,
                            input logic last, output logic ok);
    s_axi.tvalid = 1'b1;
    s_axi.tdata  = data;
    s_axi.tkeep  = keep;
    s_axi.tlast  = last;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_axi.tready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (ok) begin
      exp_q.push_back(beat_sym(data, keep));
      if (last) exp_q.push_back(ctrl0(ECP_C));
    end else begin
      check("beat_accept_timeout", 1'b0, "tready never high within 200 cycles, required accept");
    end
  endtask

  task automatic send_frame(input int nbeats, input logic [LANES-1:0] last_keep);
    logic ok;
    exp_q.push_back(ctrl0(SCP_C));
    for (int b = 0; b < nbeats; b++) begin
      offer_beat(rand_data(), (b == nbeats - 1) ? last_keep : '1, b == nbeats - 1, ok);
      if (!ok) break;
    end
    s_axi.tvalid = 1'b0;
    s_axi.tlast  = 1'b0;
  endtask

  task automatic send_one(input logic [LANES*16-1:0] data, input logic [LANES-1:0] keep);
    logic ok;
    exp_q.push_back(ctrl0(SCP_C));
    offer_beat(data, keep, 1'b1, ok);
    s_axi.tvalid = 1'b0;
    s_axi.tlast  = 1'b0;
  endtask

  initial begin
    logic             ok;
    logic [LANES-1:0] lk;
    int               n;
    s_axi.tvalid = 1'b0;
    s_axi.tdata  = '0;
    s_axi.tkeep  = '0;
    s_axi.tlast  = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_data", lane_data == all_of(IDLE_C).d,
          $sformatf("got %h, required all BCBC", lane_data));
    check("reset_k", lane_k == all_of(IDLE_C).k, $sformatf("got %b, required all 11", lane_k));
    check("reset_tready", s_axi.tready == 1'b0, $sformatf("got %b, required 0", s_axi.tready));
    check("reset_abort", frame_abort == 1'b0, $sformatf("got %b, required 0", frame_abort));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    channel_up = 1'b1;
    wait_cycles(2);

    // Directed single beats: full keep, partial keep, then back-to-back frames.
    send_one(64'h0004_0003_0002_0001, 4'b1111);
    wait_cycles(3);
    send_one(rand_data(), 4'b0011);
    wait_cycles(2);
    send_one(rand_data(), 4'b1111);
    send_one(rand_data(), 4'b0001);
    wait_cycles(2);
    send_frame(10, 4'b1111);
    send_frame(2, 4'b0000);
    wait_cycles(3);

    // Channel loss while the third beat waits for acceptance.
    exp_q.push_back(ctrl0(SCP_C));
    offer_beat(rand_data(), '1, 1'b0, ok);
    offer_beat(rand_data(), '1, 1'b0, ok);
    s_axi.tvalid = 1'b1;
    s_axi.tdata  = rand_data();
    s_axi.tkeep  = '1;
    s_axi.tlast  = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = s_axi.tready;
    end
    check("tready_before_drop", ok, "tready stayed 0, required 1 in data phase");
    channel_up = 1'b0;
    #1;
    check("tready_on_drop", s_axi.tready == 1'b0,
          $sformatf("got %b, required 0", s_axi.tready));
    abort_exp++;
    @(posedge clk);
    #1;
    s_axi.tvalid = 1'b0;
    wait_cycles(4);
    channel_up = 1'b1;
    wait_cycles(2);

    // Reset mid-frame: silent drop, then a fresh frame.
    exp_q.push_back(ctrl0(SCP_C));
    offer_beat(rand_data(), '1, 1'b0, ok);
    offer_beat(rand_data(), '1, 1'b0, ok);
    s_axi.tdata = rand_data();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_data", lane_data == all_of(IDLE_C).d,
          $sformatf("got %h, required all BCBC", lane_data));
    check("midreset_k", lane_k == all_of(IDLE_C).k, $sformatf("got %b, required all 11", lane_k));
    check("midreset_tready", s_axi.tready == 1'b0,
          $sformatf("got %b, required 0", s_axi.tready));
    exp_q.delete();
    s_axi.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_one(rand_data(), 4'b0111);

    // Randomised frames with random idle gaps.
    for (int f = 0; f < 20; f++) begin
      n  = $urandom_range(0, LANES);
      lk = '0;
      for (int i = 0; i < n; i++) lk[i] = 1'b1;
      send_frame($urandom_range(1, 6), lk);
      wait_cycles($urandom_range(0, 3));
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) wait_cycles(1);
    wait_cycles(3);
    check("drain", exp_q.size() == 0, $sformatf("%0d symbols outstanding, required 0", exp_q.size()));
    check("abort_pulses", abort_seen == abort_exp,
          $sformatf("got %0d abort cycles, required %0d", abort_seen, abort_exp));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
